// File: rtl/riscv_branch_resolve.sv
// Branch resolution: decodes taken/not-taken, detects mispredicts, drives fetch redirect + flush, trains a 2-bit BHT.
// Latency 1 from EX transfer to redirect/BHT/counter effects; ex_ready drops while a redirect is pending or flushing.
module riscv_branch_resolve #(
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_branch,
  input  logic              ex_is_jump,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_target,
  input  logic              ex_pred_taken,
  output logic              br_un,
  input  logic              br_eq,
  input  logic              br_lt,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [31:0]       redirect_pc,
  output logic              flush,
  input  logic [31:0]       if_pc,
  output logic              if_pred_taken,
  output logic              illegal_br,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {
    IDLE,
    REDIR,
    FLUSH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             in_idle;
  logic             xfer;
  logic             is_cond;
  logic             bad_f3;
  logic             cond_taken;
  logic             taken;
  logic             mispred;
  logic [31:0]      fall_pc;

  logic             upd_vld;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             res_vld;
  logic             res_mispred;

  logic [1:0]       bht [BHT_ENTRIES];

  logic             unused_pc_bits;

  // Comparator signedness comes straight from funct3 so the EX comparator settles in the same cycle.
  assign br_un = ex_funct3[1];

  assign in_idle = (state == IDLE);
  assign xfer    = ex_valid && in_idle && (ex_is_branch || ex_is_jump);
  assign is_cond = ex_is_branch && !ex_is_jump;
  assign bad_f3  = (ex_funct3[2:1] == 2'b01);

  always_comb begin
    cond_taken = 1'b0;
    case (ex_funct3)
      3'b000:         cond_taken = br_eq;
      3'b001:         cond_taken = !br_eq;
      3'b100, 3'b110: cond_taken = br_lt;
      3'b101, 3'b111: cond_taken = !br_lt;
      default:        cond_taken = 1'b0;
    endcase
  end

  assign taken   = ex_is_jump || (is_cond && cond_taken);
  assign mispred = (taken != ex_pred_taken);
  assign fall_pc = ex_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    ex_ready       = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    case (state)
      IDLE: begin
        ex_ready = 1'b1;
        if (xfer && mispred) begin
          state_nxt = REDIR;
        end
      end
      REDIR: begin
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        flush     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only a mispredicted transfer loads redirect_pc, so it stays frozen for the whole REDIR wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc <= 32'd0;
    end else if (xfer && mispred) begin
      redirect_pc <= taken ? ex_target : fall_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_vld     <= 1'b0;
      upd_idx     <= '0;
      upd_taken   <= 1'b0;
      res_vld     <= 1'b0;
      res_mispred <= 1'b0;
      illegal_br  <= 1'b0;
    end else begin
      upd_vld     <= xfer && is_cond && !bad_f3;
      upd_idx     <= ex_pc[IDX_W+1:2];
      upd_taken   <= taken;
      res_vld     <= xfer;
      res_mispred <= xfer && mispred;
      illegal_br  <= xfer && is_cond && bad_f3;
    end
  end

  // Writes land at the clock edge, so a lookup in the update cycle still sees the old counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (upd_vld) begin
      if (upd_taken) begin
        if (bht[upd_idx] != 2'b11) begin
          bht[upd_idx] <= bht[upd_idx] + 2'd1;
        end
      end else if (bht[upd_idx] != 2'b00) begin
        bht[upd_idx] <= bht[upd_idx] - 2'd1;
      end
    end
  end

  assign if_pred_taken  = bht[if_pc[IDX_W+1:2]][1];
  assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (res_vld && !(&branch_cnt)) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (res_mispred && !(&mispred_cnt)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_branch_resolve.sv
// Scoreboard bench for riscv_branch_resolve: expected redirect PCs are queued at drive time and popped when redirect_valid shows.
module tb_riscv_branch_resolve;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        br_un;
  logic        br_eq;
  logic        br_lt;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        illegal_br;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;

  logic [31:0] op_a;
  logic [31:0] op_b;

  int n_tests;
  int n_fail;

  logic [31:0] exp_q[$];
  logic [1:0]  m_bht [16];
  logic [15:0] m_branch;
  logic [15:0] m_mispred;
  logic        pend_vld;
  logic        pend_upd;
  logic [3:0]  pend_idx;
  logic        pend_tk;
  logic        pend_mis;

  riscv_branch_resolve #(.BHT_ENTRIES(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken),
    .br_un(br_un), .br_eq(br_eq), .br_lt(br_lt),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .illegal_br(illegal_br),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  // Behavioural comparator fed by the DUT's signedness select.
  assign br_eq = (op_a == op_b);
  assign br_lt = br_un ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic model_taken(input logic is_br, input logic is_j, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
    logic eq, ltu, lts;
    eq  = (a == b);
    ltu = (a < b);
    lts = ($signed(a) < $signed(b));
    if (is_j) return 1'b1;
    if (!is_br) return 1'b0;
    case (f3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lts;
      3'b101:  return !lts;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_branch  = '0;
    m_mispred = '0;
    pend_vld  = 1'b0;
    pend_upd  = 1'b0;
    pend_mis  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pend_vld) begin
      if (pend_upd) begin
        if (pend_tk) begin
          if (m_bht[pend_idx] != 2'b11) m_bht[pend_idx] = m_bht[pend_idx] + 2'd1;
        end else if (m_bht[pend_idx] != 2'b00) begin
          m_bht[pend_idx] = m_bht[pend_idx] - 2'd1;
        end
      end
      if (m_branch != 16'hFFFF) m_branch = m_branch + 16'd1;
      if (pend_mis && m_mispred != 16'hFFFF) m_mispred = m_mispred + 16'd1;
      pend_vld = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    ex_valid       = 1'b0;
    redirect_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One EX offer for one clock; the model records what the DUT should do with it.
  task automatic drive_ex(input logic is_br, input logic is_j, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                          input logic [31:0] a, input logic [31:0] b);
    logic tk, ill;
    ex_valid      = 1'b1;
    ex_is_branch  = is_br;
    ex_is_jump    = is_j;
    ex_funct3     = f3;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pred;
    op_a          = a;
    op_b          = b;
    tk  = model_taken(is_br, is_j, f3, a, b);
    ill = is_br && !is_j && (f3 == 3'b010 || f3 == 3'b011);
    tick();
    ex_valid = 1'b0;
    pend_vld = 1'b1;
    pend_upd = is_br && !is_j && !ill;
    pend_idx = pc[5:2];
    pend_tk  = tk;
    pend_mis = (tk != pred);
    if (tk != pred) exp_q.push_back(tk ? tgt : pc + 32'd4);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready: got %b expected 1", ex_ready); end
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_redirect_valid: got %b expected 0", redirect_valid); end
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b expected 0", flush); end
    n_tests++; if (illegal_br !== 1'b0) begin n_fail++; $display("FAIL reset_illegal_br: got %b expected 0", illegal_br); end
    n_tests++; if (redirect_pc !== 32'd0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
    n_tests++; if (branch_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_branch_cnt: got %0d expected 0", branch_cnt); end
    n_tests++; if (mispred_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_mispred_cnt: got %0d expected 0", mispred_cnt); end
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i) << 2;
      #1;
      n_tests++;
      if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_bht[%0d]: got %b expected 0", i, if_pred_taken); end
    end
  endtask

  task automatic test_beq_mispredict();
    logic [31:0] e;
    int w;
    do_reset();
    drive_ex(1'b1, 1'b0, 3'b000, 32'h100, 32'h180, 1'b0, 32'h55, 32'h55);
    n_tests++; if (br_un !== 1'b0) begin n_fail++; $display("FAIL beq_br_un: got %b expected 0", br_un); end
    n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL beq_redirect_next_cycle: got %b expected 1", redirect_valid); end
    n_tests++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL beq_ex_ready: got %b expected 0", ex_ready); end
    w = 0;
    while (redirect_valid !== 1'b1 && w < 8) begin tick(); w++; end
    e = exp_q.pop_front();
    n_tests++; if (redirect_pc !== e) begin n_fail++; $display("FAIL beq_redirect_pc: got %h expected %h", redirect_pc, e); end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL beq_flush: got %b expected 1", flush); end
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL beq_redirect_drop: got %b expected 0", redirect_valid); end
    tick();
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL beq_flush_one_cycle: got %b expected 0", flush); end
    n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL beq_back_idle: got %b expected 1", ex_ready); end
    n_tests++; if (mispred_cnt !== m_mispred) begin n_fail++; $display("FAIL beq_mispred_cnt: got %0d expected %0d", mispred_cnt, m_mispred); end
  endtask

  task automatic test_bltu_not_taken();
    do_reset();
    if_pc = 32'h204;
    drive_ex(1'b1, 1'b0, 3'b110, 32'h204, 32'h280, 1'b0, 32'hFFFF_F000, 32'h0FFF_FFFF);
    n_tests++; if (br_un !== 1'b1) begin n_fail++; $display("FAIL bltu_br_un: got %b expected 1", br_un); end
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bltu_no_redirect: got %b expected 0", redirect_valid); end
    tick();
    n_tests++; if (branch_cnt !== m_branch) begin n_fail++; $display("FAIL bltu_branch_cnt: got %0d expected %0d", branch_cnt, m_branch); end
    n_tests++; if (if_pred_taken !== m_bht[1][1]) begin n_fail++; $display("FAIL bltu_bht_after: got %b expected %b", if_pred_taken, m_bht[1][1]); end
    // A taken update from 00 must leave the prediction at not-taken; from 01 it would flip.
    drive_ex(1'b1, 1'b0, 3'b110, 32'h204, 32'h280, 1'b1, 32'd1, 32'd2);
    tick();
    n_tests++; if (if_pred_taken !== m_bht[1][1]) begin n_fail++; $display("FAIL bltu_bht_was_00: got %b expected %b", if_pred_taken, m_bht[1][1]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    if_pc = 32'h308;
    drive_ex(1'b1, 1'b0, 3'b101, 32'h308, 32'h400, 1'b1, 32'd5, 32'd3);
    n_tests++; if (if_pred_taken !== m_bht[2][1]) begin n_fail++; $display("FAIL b2b_pre_update_lookup: got %b expected %b", if_pred_taken, m_bht[2][1]); end
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_redirect: got %b expected 0", redirect_valid); end
    drive_ex(1'b1, 1'b0, 3'b101, 32'h308, 32'h400, 1'b1, 32'd5, 32'd3);
    n_tests++; if (if_pred_taken !== m_bht[2][1]) begin n_fail++; $display("FAIL b2b_bht_10: got %b expected %b", if_pred_taken, m_bht[2][1]); end
    drive_ex(1'b1, 1'b0, 3'b101, 32'h308, 32'h400, 1'b1, 32'd5, 32'd3);
    n_tests++; if (if_pred_taken !== m_bht[2][1]) begin n_fail++; $display("FAIL b2b_bht_11: got %b expected %b", if_pred_taken, m_bht[2][1]); end
    tick();
    n_tests++; if (if_pred_taken !== 1'b1) begin n_fail++; $display("FAIL b2b_bht_sat: got %b expected 1", if_pred_taken); end
    n_tests++; if (branch_cnt !== m_branch) begin n_fail++; $display("FAIL b2b_branch_cnt: got %0d expected %0d", branch_cnt, m_branch); end
    n_tests++; if (mispred_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b_mispred_cnt: got %0d expected 0", mispred_cnt); end
    // Signed -1 < 3, so BGE is not taken; an unsigned compare would wrongly redirect.
    drive_ex(1'b1, 1'b0, 3'b101, 32'h308, 32'h400, 1'b0, 32'hFFFF_FFFF, 32'd3);
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_signed_cmp: got %b expected 0", redirect_valid); end
    tick();
    n_tests++; if (if_pred_taken !== m_bht[2][1]) begin n_fail++; $display("FAIL b2b_bht_dec_from_11: got %b expected %b", if_pred_taken, m_bht[2][1]); end
  endtask

  task automatic test_illegal();
    if_pc = 32'h308;
    drive_ex(1'b1, 1'b0, 3'b011, 32'h308, 32'h500, 1'b0, 32'd9, 32'd9);
    n_tests++; if (illegal_br !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse: got %b expected 1", illegal_br); end
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_not_taken: got %b expected 0", redirect_valid); end
    tick();
    n_tests++; if (illegal_br !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse_width: got %b expected 0", illegal_br); end
    n_tests++; if (if_pred_taken !== m_bht[2][1]) begin n_fail++; $display("FAIL illegal_bht_unchanged: got %b expected %b", if_pred_taken, m_bht[2][1]); end
    n_tests++; if (branch_cnt !== m_branch) begin n_fail++; $display("FAIL illegal_counted: got %0d expected %0d", branch_cnt, m_branch); end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    int w;
    do_reset();
    drive_ex(1'b0, 1'b1, 3'b000, 32'h1000, 32'h4000, 1'b0, 32'd0, 32'd0);
    w = 0;
    while (redirect_valid !== 1'b1 && w < 8) begin tick(); w++; end
    n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL stall_redirect_timeout: got %b expected 1", redirect_valid); end
    e = exp_q.pop_front();
    // Offer another branch during the stall; it must not be taken in.
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_is_jump = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", c, redirect_valid); end
      n_tests++; if (redirect_pc !== e) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h expected %h", c, redirect_pc, e); end
      n_tests++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ex_ready[%0d]: got %b expected 0", c, ex_ready); end
      n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL stall_flush[%0d]: got %b expected 0", c, flush); end
      tick();
    end
    ex_valid = 1'b0;
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL stall_flush_after_accept: got %b expected 1", flush); end
    tick();
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL stall_flush_one_cycle: got %b expected 0", flush); end
    n_tests++; if (branch_cnt !== m_branch) begin n_fail++; $display("FAIL stall_no_extra_accept: got %0d expected %0d", branch_cnt, m_branch); end
  endtask

  // No reset here: redirect_pc still holds the previous target, so the wrapped 0 must be written.
  task automatic test_wrap();
    logic [31:0] e;
    int w;
    drive_ex(1'b1, 1'b0, 3'b001, 32'hFFFF_FFFC, 32'h10, 1'b1, 32'd7, 32'd7);
    w = 0;
    while (redirect_valid !== 1'b1 && w < 8) begin tick(); w++; end
    n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_redirect_timeout: got %b expected 1", redirect_valid); end
    e = exp_q.pop_front();
    n_tests++; if (redirect_pc !== e) begin n_fail++; $display("FAIL wrap_redirect_pc: got %h expected %h", redirect_pc, e); end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    tick();
    n_tests++; if (mispred_cnt !== m_mispred) begin n_fail++; $display("FAIL wrap_mispred_cnt: got %0d expected %0d", mispred_cnt, m_mispred); end
  endtask

  task automatic test_reset_in_redir();
    logic [31:0] e;
    do_reset();
    drive_ex(1'b1, 1'b0, 3'b000, 32'h104, 32'h200, 1'b1, 32'd1, 32'd1);
    drive_ex(1'b1, 1'b0, 3'b000, 32'h100, 32'h180, 1'b0, 32'd4, 32'd4);
    n_tests++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL rstredir_in_redir: got %b expected 1", redirect_valid); end
    e = exp_q.pop_front();
    n_tests++; if (redirect_pc !== e) begin n_fail++; $display("FAIL rstredir_pc: got %h expected %h", redirect_pc, e); end
    rst = 1'b1;
    redirect_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    redirect_ready = 1'b0;
    model_reset();
    n_tests++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rstredir_idle: got %b expected 1", ex_ready); end
    n_tests++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rstredir_valid: got %b expected 0", redirect_valid); end
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rstredir_flush: got %b expected 0", flush); end
    n_tests++; if (redirect_pc !== 32'd0) begin n_fail++; $display("FAIL rstredir_redirect_pc: got %h expected 0", redirect_pc); end
    n_tests++; if (branch_cnt !== 16'd0) begin n_fail++; $display("FAIL rstredir_branch_cnt: got %0d expected 0", branch_cnt); end
    n_tests++; if (mispred_cnt !== 16'd0) begin n_fail++; $display("FAIL rstredir_mispred_cnt: got %0d expected 0", mispred_cnt); end
    tick();
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rstredir_no_late_flush: got %b expected 0", flush); end
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i) << 2;
      #1;
      n_tests++;
      if (if_pred_taken !== 1'b0) begin n_fail++; $display("FAIL rstredir_bht[%0d]: got %b expected 0", i, if_pred_taken); end
    end
    // One taken update must flip index 0, proving it restarted at 01.
    if_pc = 32'h100;
    drive_ex(1'b1, 1'b0, 3'b000, 32'h100, 32'h180, 1'b1, 32'd4, 32'd4);
    tick();
    n_tests++; if (if_pred_taken !== m_bht[0][1]) begin n_fail++; $display("FAIL rstredir_bht_01: got %b expected %b", if_pred_taken, m_bht[0][1]); end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_is_jump     = 1'b0;
    ex_funct3      = 3'b000;
    ex_pc          = 32'd0;
    ex_target      = 32'd0;
    ex_pred_taken  = 1'b0;
    redirect_ready = 1'b0;
    if_pc          = 32'd0;
    op_a           = 32'd0;
    op_b           = 32'd0;
    model_reset();

    test_reset();
    test_beq_mispredict();
    test_bltu_not_taken();
    test_back_to_back();
    test_illegal();
    test_stall();
    test_wrap();
    test_reset_in_redir();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending redirects expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_branch_resolve.md
RISCV_BRANCH_RESOLVE -- requirements
Module: riscv_branch_resolve

Interface
REQ-001 Parameter BHT_ENTRIES, default 16, number of 2-bit branch history counters (power of 2, 4..64).
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ex_valid  input  1  EX stage offers a control-flow instruction this cycle.
REQ-006 ex_ready  output  1  unit accepts the EX offer; a transfer occurs when ex_valid && ex_ready.
REQ-007 ex_is_branch  input  1  conditional branch (B-type).
REQ-008 ex_is_jump  input  1  unconditional jump (JAL/JALR).
REQ-009 ex_funct3  input  3  branch condition code.
REQ-010 ex_pc  input  32  instruction PC.
REQ-011 ex_target  input  32  computed taken target.
REQ-012 ex_pred_taken  input  1  direction predicted at fetch.
REQ-013 br_un  output  1  unsigned-compare select driven to the branch comparator.
REQ-014 br_eq  input  1  comparator equal result.
REQ-015 br_lt  input  1  comparator less-than result (signed or unsigned per br_un).
REQ-016 redirect_valid  output  1  fetch redirect request.
REQ-017 redirect_ready  input  1  fetch accepts the redirect.
REQ-018 redirect_pc  output  32  new fetch PC.
REQ-019 flush  output  1  one-cycle kill of IF/ID younger instructions.
REQ-020 if_pc  input  32  fetch PC for prediction lookup.
REQ-021 if_pred_taken  output  1  combinational prediction: MSB of BHT[if_pc[log2(BHT_ENTRIES)+1:2]].
REQ-022 illegal_br  output  1  one-cycle pulse: accepted branch had funct3 010 or 011.
REQ-023 branch_cnt, mispred_cnt  output  CNT_W each  resolved-branch and mispredict counters.

Function
REQ-024 br_un SHALL equal ex_funct3[1], combinationally.
REQ-025 Taken decode: 000 br_eq; 001 !br_eq; 100/110 br_lt; 101/111 !br_lt; 010/011 not taken; ex_is_jump always taken (overrides ex_is_branch).
REQ-026 On transfer, the unit SHALL register taken, pc, target, pred; outcome is acted on the following cycle (latency 1).
REQ-027 Mispredict = taken != pred; redirect_pc = taken ? target : pc + 4 (32-bit wrap, 0xFFFF_FFFC+4 = 0).
REQ-028 FSM states IDLE, REDIR, FLUSH; ex_ready = 1 only in IDLE.
REQ-029 IDLE: on a transfer with mispredict, go to REDIR; otherwise stay in IDLE.
REQ-030 REDIR: redirect_valid = 1 with redirect_pc held stable; on redirect_ready go to FLUSH, otherwise stay.
REQ-031 FLUSH: flush = 1 for exactly one cycle, then go to IDLE.
REQ-032 Outside REDIR, redirect_valid = 0; outside FLUSH, flush = 0.
REQ-033 BHT update SHALL occur one cycle after each accepted branch (not jumps, not illegal): saturating increment if taken, decrement if not; 11 and 00 saturate.
REQ-034 Same-cycle BHT update and if_pc lookup of the same index SHALL return the pre-update value.
REQ-035 branch_cnt increments per accepted branch or jump; mispred_cnt increments per mispredict; both saturate at all-ones.
REQ-036 An illegal funct3 SHALL be treated as not taken, pulse illegal_br, and still count.

Reset
REQ-037 rst SHALL force FSM to IDLE, every BHT entry to 01, counters to 0, redirect_valid/flush/illegal_br to 0, redirect_pc to 0.
REQ-038 rst asserted in REDIR or FLUSH SHALL abandon the redirect; no flush pulse follows.

Verification
REQ-039 BEQ, br_eq=1, pred=0, pc 0x100, target 0x180 -> redirect_valid next cycle, redirect_pc 0x180, ex_ready=0, flush 1 cycle after redirect_ready.
REQ-040 BLTU (110), comparator inputs 0xFFFF_F000 vs 0x0FFF_FFFF -> br_un=1, br_lt=0, pred=0 -> no redirect, branch_cnt=1, BHT[pc] 01->00.
REQ-041 BGE (101), br_lt=0, pred=1 -> not mispredicted; 3 taken updates on one index -> 01->10->11->11, if_pred_taken=1.
REQ-042 Mispredict with redirect_ready held low 5 cycles -> redirect_valid/redirect_pc stable 5 cycles, ex_ready=0, flush only after acceptance.
REQ-043 funct3=011 with br_eq=1 -> not taken, illegal_br pulses once, no BHT change.
REQ-044 rst asserted during REDIR -> next cycle IDLE, redirect_valid=0, no flush, counters 0, all BHT entries 01.
